// File: rtl/stage_execute_pipe.sv
// rtl/stage_execute_pipe.sv - registered execute stage: ALU, address generation, control-flow resolution.
// Define EXEC_MULDIV_EN to build the iterative signed multiply/divide unit and its BUSY state.
module stage_execute_pipe #(
    parameter int DW  = 32,
    parameter int PCW = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    insn,
    input  logic [DW-1:0]  operand_a,
    input  logic [DW-1:0]  operand_b,
    input  logic [PCW-1:0] pc_plus_1,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_insn,
    output logic [DW-1:0]  o_out,
    output logic [DW-1:0]  b_out,
    output logic           overflow,
    output logic           redirect_valid,
    output logic [PCW-1:0] redirect_pc
);

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t         r_state;
    logic           r_out_valid;
    logic [31:0]    r_out_insn;
    logic [DW-1:0]  r_o_out;
    logic [DW-1:0]  r_b_out;
    logic           r_overflow;
    logic           r_redirect_valid;
    logic [PCW-1:0] r_redirect_pc;

    logic [4:0]     w_opcode;
    logic [4:0]     w_aluop;
    logic [4:0]     w_shamt;
    logic [DW-1:0]  w_imm_dw;
    logic [PCW-1:0] w_imm_pc;
    logic [PCW-1:0] w_jump_tgt;
    logic [PCW-1:0] w_br_tgt;
    logic [PCW-1:0] w_jr_tgt;
    logic [DW-1:0]  w_pc_dw;
    logic [DW-1:0]  w_sum;
    logic [DW-1:0]  w_diff;
    logic [DW-1:0]  w_addi;
    logic           w_add_ovf;
    logic           w_sub_ovf;
    logic           w_addi_ovf;
    logic [DW-1:0]  w_res;
    logic           w_ovf;
    logic           w_taken;
    logic [PCW-1:0] w_target;
    logic           w_is_md;
    logic           w_accept;
    logic           w_unused;

    assign w_opcode = insn[31:27];
    assign w_aluop  = insn[6:2];
    assign w_shamt  = insn[11:7];
    assign w_unused = ^insn[1:0];

    assign w_imm_dw = DW'($signed(insn[16:0]));
    assign w_imm_pc = PCW'($signed(insn[16:0]));
    // Upper PC bits survive only when PCW is wider than the 27-bit jump field.
    assign w_jump_tgt = (pc_plus_1 & ~PCW'(27'h7FF_FFFF)) | PCW'(insn[26:0]);
    assign w_br_tgt   = pc_plus_1 + w_imm_pc;
    assign w_jr_tgt   = PCW'(operand_b);
    assign w_pc_dw    = DW'(pc_plus_1);

    assign w_sum  = operand_a + operand_b;
    assign w_diff = operand_a - operand_b;
    assign w_addi = operand_a + w_imm_dw;
    assign w_add_ovf  = (operand_a[DW-1] == operand_b[DW-1]) & (w_sum[DW-1] != operand_a[DW-1]);
    assign w_sub_ovf  = (operand_a[DW-1] != operand_b[DW-1]) & (w_diff[DW-1] != operand_a[DW-1]);
    assign w_addi_ovf = (operand_a[DW-1] == w_imm_dw[DW-1]) & (w_addi[DW-1] != operand_a[DW-1]);

    assign in_ready = (r_state == S_IDLE) & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_res    = '0;
        w_ovf    = 1'b0;
        w_taken  = 1'b0;
        w_target = w_br_tgt;
        w_is_md  = 1'b0;
        case (w_opcode)
            OP_ALU: begin
                case (w_aluop)
                    5'd0: begin w_res = w_sum;  w_ovf = w_add_ovf; end
                    5'd1: begin w_res = w_diff; w_ovf = w_sub_ovf; end
                    5'd2: w_res = operand_a & operand_b;
                    5'd3: w_res = operand_a | operand_b;
                    5'd4: w_res = operand_a << w_shamt;
                    5'd5: w_res = $signed(operand_a) >>> w_shamt;
                    5'd6, 5'd7: begin
`ifdef EXEC_MULDIV_EN
                        w_is_md = 1'b1;
`else
                        w_ovf = 1'b1;
`endif
                    end
                    default: w_res = '0;
                endcase
            end
            OP_ADDI: begin w_res = w_addi; w_ovf = w_addi_ovf; end
            OP_SW, OP_LW: w_res = w_addi;
            OP_BNE: w_taken = (operand_a != operand_b);
            OP_BLT: w_taken = ($signed(operand_b) < $signed(operand_a));
            OP_BEX: begin w_taken = (operand_a != '0); w_target = w_jump_tgt; end
            OP_J:   begin w_taken = 1'b1; w_target = w_jump_tgt; end
            OP_JAL: begin w_taken = 1'b1; w_target = w_jump_tgt; w_res = w_pc_dw; end
            OP_JR:  begin w_taken = 1'b1; w_target = w_jr_tgt; end
            default: w_res = '0;
        endcase
    end

`ifdef EXEC_MULDIV_EN
    localparam int CW = $clog2(DW + 1);

    // Shared datapath: mul shifts the product right through {hi,lo}; div shifts the dividend left.
    logic [DW-1:0]   r_md_hi;
    logic [DW-1:0]   r_md_lo;
    logic [DW-1:0]   r_md_den;
    logic [CW-1:0]   r_md_cnt;
    logic            r_md_div;
    logic            r_md_neg;
    logic            r_md_dz;
    logic            r_md_ovf_div;

    logic [DW-1:0]   w_abs_a;
    logic [DW-1:0]   w_abs_b;
    logic [DW:0]     w_mul_sum;
    logic [DW:0]     w_div_shift;
    logic            w_div_ge;
    logic [DW-1:0]   w_div_sub;
    logic [2*DW-1:0] w_prod_mag;
    logic [2*DW-1:0] w_prod;
    logic            w_mul_ovf;
    logic [DW-1:0]   w_quot;
    logic [DW-1:0]   w_md_res;
    logic            w_md_ovf;

    assign w_abs_a     = operand_a[DW-1] ? -operand_a : operand_a;
    assign w_abs_b     = operand_b[DW-1] ? -operand_b : operand_b;
    assign w_mul_sum   = {1'b0, r_md_hi} + (r_md_lo[0] ? {1'b0, r_md_den} : '0);
    assign w_div_shift = {r_md_hi, r_md_lo[DW-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_md_den});
    assign w_div_sub   = w_div_shift[DW-1:0] - r_md_den;
    assign w_prod_mag  = {r_md_hi, r_md_lo};
    assign w_prod      = r_md_neg ? -w_prod_mag : w_prod_mag;
    assign w_mul_ovf   = ~((&w_prod[2*DW-1:DW-1]) | ~(|w_prod[2*DW-1:DW-1]));
    assign w_quot      = r_md_neg ? -r_md_lo : r_md_lo;
    assign w_md_res    = r_md_div ? (r_md_dz ? '0 : w_quot) : w_prod[DW-1:0];
    assign w_md_ovf    = r_md_div ? (r_md_dz | r_md_ovf_div) : w_mul_ovf;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_out_valid      <= 1'b0;
            r_out_insn       <= '0;
            r_o_out          <= '0;
            r_b_out          <= '0;
            r_overflow       <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
`ifdef EXEC_MULDIV_EN
            r_md_hi      <= '0;
            r_md_lo      <= '0;
            r_md_den     <= '0;
            r_md_cnt     <= '0;
            r_md_div     <= 1'b0;
            r_md_neg     <= 1'b0;
            r_md_dz      <= 1'b0;
            r_md_ovf_div <= 1'b0;
`endif
        end else begin
            r_redirect_valid <= 1'b0;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_out_insn <= insn;
                        r_b_out    <= operand_b;
                        if (w_taken) begin
                            r_redirect_valid <= 1'b1;
                            r_redirect_pc    <= w_target;
                        end
                        if (w_is_md) begin
`ifdef EXEC_MULDIV_EN
                            r_state      <= S_BUSY;
                            r_md_div     <= w_aluop[0];
                            r_md_den     <= w_aluop[0] ? w_abs_b : w_abs_a;
                            r_md_lo      <= w_aluop[0] ? w_abs_a : w_abs_b;
                            r_md_hi      <= '0;
                            r_md_cnt     <= '0;
                            r_md_neg     <= operand_a[DW-1] ^ operand_b[DW-1];
                            r_md_dz      <= ~(|operand_b);
                            r_md_ovf_div <= (operand_a == {1'b1, {(DW-1){1'b0}}}) & (&operand_b);
`endif
                        end else begin
                            r_out_valid <= 1'b1;
                            r_o_out     <= w_res;
                            r_overflow  <= w_ovf;
                        end
                    end
                end
                S_BUSY: begin
`ifdef EXEC_MULDIV_EN
                    // DW iterations, then one cycle for sign fix-up and the result load.
                    if (r_md_cnt == CW'(DW)) begin
                        r_o_out     <= w_md_res;
                        r_overflow  <= w_md_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_md_cnt <= r_md_cnt + CW'(1);
                        if (r_md_div) begin
                            if (w_div_ge) begin
                                r_md_hi <= w_div_sub;
                                r_md_lo <= {r_md_lo[DW-2:0], 1'b1};
                            end else begin
                                r_md_hi <= w_div_shift[DW-1:0];
                                r_md_lo <= {r_md_lo[DW-2:0], 1'b0};
                            end
                        end else begin
                            r_md_hi <= w_mul_sum[DW:1];
                            r_md_lo <= {w_mul_sum[0], r_md_lo[DW-1:1]};
                        end
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid      = r_out_valid;
    assign out_insn       = r_out_insn;
    assign o_out          = r_o_out;
    assign b_out          = r_b_out;
    assign overflow       = r_overflow;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_stage_execute_pipe.sv
// tb/tb_stage_execute_pipe.sv - randomized and directed bench for stage_execute_pipe against a queue-based reference model.
module tb_stage_execute_pipe;

    localparam int DW  = 32;
    localparam int PCW = 32;

    logic           clock = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    insn;
    logic [DW-1:0]  operand_a;
    logic [DW-1:0]  operand_b;
    logic [PCW-1:0] pc_plus_1;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_insn;
    logic [DW-1:0]  o_out;
    logic [DW-1:0]  b_out;
    logic           overflow;
    logic           redirect_valid;
    logic [PCW-1:0] redirect_pc;

    stage_execute_pipe #(.DW(DW), .PCW(PCW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .insn(insn), .operand_a(operand_a), .operand_b(operand_b), .pc_plus_1(pc_plus_1),
        .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
        .o_out(o_out), .b_out(b_out), .overflow(overflow),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] res;
        logic [31:0] b;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          n = 0;
    logic        exp_rv = 1'b0;
    logic [31:0] exp_rpc = '0;
    logic        acc_flag = 1'b0;
    logic [4:0]  op_tab [0:11];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic void model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] pc, output logic [31:0] res, output logic ovf,
                                  output logic taken, output logic [31:0] tgt, output logic md);
        longint sa, sb, full, imm;
        logic signed [16:0] i17;
        logic [31:0] jt;
        sa = sx(a);
        sb = sx(b);
        i17 = i[16:0];
        imm = longint'(i17);
        jt = {pc[31:27], i[26:0]};
        res = '0; ovf = 1'b0; taken = 1'b0; tgt = '0; md = 1'b0;
        case (i[31:27])
            5'd0: begin
                case (i[6:2])
                    5'd0: begin full = sa + sb; res = full[31:0]; ovf = (full != sx(res)); end
                    5'd1: begin full = sa - sb; res = full[31:0]; ovf = (full != sx(res)); end
                    5'd2: res = a & b;
                    5'd3: res = a | b;
                    5'd4: res = a << i[11:7];
                    5'd5: res = $signed(a) >>> i[11:7];
`ifdef EXEC_MULDIV_EN
                    5'd6: begin md = 1'b1; full = sa * sb; res = full[31:0]; ovf = (full != sx(res)); end
                    5'd7: begin
                        md = 1'b1;
                        if (b == 32'd0) begin res = '0; ovf = 1'b1; end
                        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin res = a; ovf = 1'b1; end
                        else begin full = sa / sb; res = full[31:0]; end
                    end
`else
                    5'd6, 5'd7: ovf = 1'b1;
`endif
                    default: res = '0;
                endcase
            end
            5'd5: begin full = sa + imm; res = full[31:0]; ovf = (full != sx(res)); end
            5'd7, 5'd8: begin full = sa + imm; res = full[31:0]; end
            5'd2: begin taken = (a != b); full = longint'(pc) + imm; tgt = full[31:0]; end
            5'd6: begin taken = (sb < sa); full = longint'(pc) + imm; tgt = full[31:0]; end
            5'd22: begin taken = (a != 0); tgt = jt; end
            5'd1: begin taken = 1'b1; tgt = jt; end
            5'd3: begin taken = 1'b1; tgt = jt; res = pc; end
            5'd4: begin taken = 1'b1; tgt = b; end
            default: res = '0;
        endcase
    endfunction

    // One cycle: check outputs at the falling edge, advance the model, then move past the rising edge.
    task automatic step();
        logic exp_ov, md_pend, exp_ir, ovf, tk, md;
        logic [31:0] res, tgt;
        exp_t e;
        @(negedge clock);
        n++;
        acc_flag = 1'b0;
        exp_ov = (q.size() > 0) && (q[0].due <= n);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_insn", out_insn, q[0].insn);
            chk("o_out", o_out, q[0].res);
            chk("b_out", b_out, q[0].b);
            chk("overflow", overflow, q[0].ovf);
        end
        chk("redirect_valid", redirect_valid, exp_rv);
        if (exp_rv) chk("redirect_pc", redirect_pc, exp_rpc);
        if (!reset) begin
            q.delete();
            exp_rv = 1'b0;
        end else begin
            md_pend = (q.size() > 0) && (q[$].due > n);
            exp_ir = !md_pend && (!exp_ov || out_ready);
            chk("in_ready", in_ready, exp_ir);
            exp_rv = 1'b0;
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ir) begin
                model(insn, operand_a, operand_b, pc_plus_1, res, ovf, tk, tgt, md);
                e.insn = insn; e.res = res; e.b = operand_b; e.ovf = ovf;
                e.due = n + (md ? DW + 1 : 1);
                q.push_back(e);
                if (tk) begin exp_rv = 1'b1; exp_rpc = tgt; end
                acc_flag = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input int rdy_pct);
        insn = i; operand_a = a; operand_b = b; pc_plus_1 = pc; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            step();
            if (acc_flag) begin
                in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < cycles; k++) step();
    endtask

    function automatic logic [31:0] mk_alu(input logic [4:0] fn);
        return {5'd0, 20'h0, fn, 2'b00};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [16:0] imm);
        return {op, 10'h0, imm};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0]  op;
        logic [31:0] ri;
        int          c;
        op_tab = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd7, 5'd8, 5'd2, 5'd6, 5'd22, 5'd1, 5'd3, 5'd4};
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        insn = '0; operand_a = '0; operand_b = '0; pc_plus_1 = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_o_out", o_out, 32'd0);
        chk("rst_b_out", b_out, 32'd0);
        chk("rst_out_insn", out_insn, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        reset = 1'b1;

        send(mk_alu(5'd0), 32'h7FFF_FFFF, 32'd1, 32'd40, 100);
        idle(2);

        send(mk_i(5'd2, 17'h1FFFE), 32'd3, 32'd4, 32'd100, 100);
        idle(2);
        send(mk_i(5'd2, 17'h1FFFE), 32'd3, 32'd3, 32'd100, 100);
        idle(2);

        c = 0;
        for (int k = 0; k < 4; k++) begin
            insn = mk_i(5'd5, 17'(k + 1));
            operand_a = (k == 3) ? 32'h7FFF_FFFF : 32'(k * 10);
            operand_b = 32'(k);
            pc_plus_1 = 32'd200;
            in_valid = 1'b1;
            do begin
                out_ready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
                step();
                c++;
            end while (!acc_flag && c < 50);
        end
        idle(3);

        send(mk_alu(5'd6), 32'hFFFF_FFFD, 32'd5, 32'd0, 100);
        idle(DW + 3);
        send(mk_alu(5'd7), 32'd7, 32'd0, 32'd0, 100);
        idle(DW + 3);
        send(mk_alu(5'd7), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 100);
        idle(DW + 3);
        send(mk_alu(5'd6), 32'd2, 32'd3, 32'd0, 100);
        idle(DW + 3);

        send(mk_alu(5'd7), 32'd100, 32'd7, 32'd0, 100);
        idle(9);
        reset = 1'b0;
        step();
        reset = 1'b1;
        send(mk_i(5'd5, 17'd9), 32'd1, 32'd2, 32'd0, 100);
        idle(3);

        for (int k = 0; k < 300; k++) begin
            op = ($urandom_range(0, 12) == 12) ? 5'($urandom) : op_tab[$urandom_range(0, 11)];
            ri = {op, 27'($urandom)};
            if (op == 5'd0) ri[6:2] = 5'($urandom_range(0, 9));
            send(ri, pick(), pick(), $urandom, $urandom_range(50, 100));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && q.size() > 0; k++) step();
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
